// File: rtl/turbo_qpp_pkg.sv
// Shared constants, ROM field layout and FSM state encoding for the QPP turbo
// interleaver address generator.
package turbo_qpp_pkg;

  localparam int K_MAX       = 6144;
  localparam int K_MIN       = 40;
  localparam int NUM_BLK_DEF = 188;
  localparam int K_W         = 13;
  localparam int F_W         = 9;
  localparam int ROM_W       = 24;

  // Word 2b carries K, word 2b+1 carries f1 and f2.
  localparam int K_LSB  = 0;
  localparam int K_MSB  = 12;
  localparam int F1_LSB = 0;
  localparam int F1_MSB = 8;
  localparam int F2_LSB = 9;
  localparam int F2_MSB = 17;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH0,
    S_FETCH1,
    S_FETCH2,
    S_INIT,
    S_GEN
  } state_t;

  function automatic logic params_ok(input logic [K_W-1:0] k,
                                     input logic [F_W-1:0] f1,
                                     input logic [F_W-1:0] f2);
    return (k[2:0] == 3'd0) && (k >= K_W'(K_MIN)) && (k <= K_W'(K_MAX)) &&
           f1[0] && ({{(K_W-F_W){1'b0}}, f2} < k);
  endfunction

endpackage

// File: rtl/turbo_qpp_mod_add.sv
// Combinational (a + b) mod k for operands already reduced below k, using a
// single conditional subtract.
module turbo_qpp_mod_add
  import turbo_qpp_pkg::*;
(
  input  logic [K_W-1:0] a,
  input  logic [K_W-1:0] b,
  input  logic [K_W-1:0] k,
  output logic [K_W-1:0] sum
);

  logic [K_W:0]   raw;
  logic [K_W-1:0] diff;

  assign raw  = {1'b0, a} + {1'b0, b};
  assign diff = K_W'(raw - {1'b0, k});
  assign sum  = (raw >= {1'b0, k}) ? diff : raw[K_W-1:0];

endmodule

// File: rtl/turbo_qpp_addr_gen.sv
// QPP interleaver address generator: fetches K/f1/f2 from a parameter ROM and
// streams pi(i) recursively. Optional macro TURBO_QPP_PARAM_CHECK_EN validates parameters.
module turbo_qpp_addr_gen
  import turbo_qpp_pkg::*;
#(
  parameter int NUM_BLK       = NUM_BLK_DEF,
  parameter int ROM_ADDR_BITS = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [7:0]               blk_idx,
  output logic                     busy,
  output logic                     err,
  output logic [ROM_ADDR_BITS-1:0] rom_addr,
  input  logic [ROM_W-1:0]         rom_data,
  output logic [K_W-1:0]           k_out,
  output logic                     addr_valid,
  input  logic                     addr_ready,
  output logic [K_W-1:0]           lin_addr,
  output logic [K_W-1:0]           int_addr,
  output logic                     last
);

  state_t         state;
  logic [7:0]     blk;
  logic [F_W-1:0] f1_reg;
  logic [F_W-1:0] f2_reg;
  logic [K_W-1:0] g_reg;
  logic [K_W-1:0] d_reg;

  logic [K_W-1:0] f1_ext;
  logic [K_W-1:0] f2_ext;
  logic [K_W-1:0] g_a;
  logic [K_W-1:0] g_b;
  logic [K_W-1:0] pi_sum;
  logic [K_W-1:0] g_sum;
  logic [K_W-1:0] d_sum;
  logic [K_W-1:0] lin_next;
  logic           params_pass;
  logic           rom_unused;

  assign f1_ext   = {{(K_W-F_W){1'b0}}, f1_reg};
  assign f2_ext   = {{(K_W-F_W){1'b0}}, f2_reg};
  assign lin_next = lin_addr + K_W'(1);
  assign rom_unused = ^rom_data[ROM_W-1:F2_MSB+1];

  // The g adder seeds g = f1+f2 in INIT and steps g += d in GEN.
  assign g_a = (state == S_INIT) ? f1_ext : g_reg;
  assign g_b = (state == S_INIT) ? f2_ext : d_reg;

  turbo_qpp_mod_add u_add_pi (.a(int_addr), .b(g_reg),  .k(k_out), .sum(pi_sum));
  turbo_qpp_mod_add u_add_g  (.a(g_a),      .b(g_b),    .k(k_out), .sum(g_sum));
  turbo_qpp_mod_add u_add_d  (.a(f2_ext),   .b(f2_ext), .k(k_out), .sum(d_sum));

`ifdef TURBO_QPP_PARAM_CHECK_EN
  assign params_pass = params_ok(k_out, f1_reg, f2_reg);
`else
  assign params_pass = 1'b1;
`endif

  // NOTE: all state uses non-blocking assignments so every register reads pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      blk        <= '0;
      f1_reg     <= '0;
      f2_reg     <= '0;
      g_reg      <= '0;
      d_reg      <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
      rom_addr   <= '0;
      k_out      <= '0;
      addr_valid <= 1'b0;
      lin_addr   <= '0;
      int_addr   <= '0;
      last       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (int'(blk_idx) < NUM_BLK) begin
              blk      <= blk_idx;
              rom_addr <= ROM_ADDR_BITS'({blk_idx, 1'b0});
              busy     <= 1'b1;
              state    <= S_FETCH0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_FETCH0: begin
          rom_addr <= ROM_ADDR_BITS'({blk, 1'b1});
          state    <= S_FETCH1;
        end
        S_FETCH1: begin
          k_out <= rom_data[K_MSB:K_LSB];
          state <= S_FETCH2;
        end
        S_FETCH2: begin
          f1_reg <= rom_data[F1_MSB:F1_LSB];
          f2_reg <= rom_data[F2_MSB:F2_LSB];
          state  <= S_INIT;
        end
        S_INIT: begin
          if (!params_pass) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            lin_addr   <= '0;
            int_addr   <= '0;
            g_reg      <= g_sum;
            d_reg      <= d_sum;
            last       <= (k_out == K_W'(1));
            addr_valid <= 1'b1;
            state      <= S_GEN;
          end
        end
        S_GEN: begin
          if (addr_valid && addr_ready) begin
            if (last) begin
              addr_valid <= 1'b0;
              last       <= 1'b0;
              busy       <= 1'b0;
              state      <= S_IDLE;
            end else begin
              lin_addr <= lin_next;
              int_addr <= pi_sum;
              g_reg    <= g_sum;
              last     <= (lin_next == k_out - K_W'(1));
            end
          end
        end
        default: begin
          addr_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_turbo_qpp_addr_gen.sv
// Directed bench for turbo_qpp_addr_gen: a small registered ROM model and a
// closed-form QPP reference pi(i) = (f1*i + f2*i*i) mod K.
module tb_turbo_qpp_addr_gen;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    blk_idx = '0;
  logic          busy;
  logic          err;
  logic [AW-1:0] rom_addr;
  logic [23:0]   rom_data = '0;
  logic [12:0]   k_out;
  logic          addr_valid;
  logic          addr_ready = 1'b0;
  logic [12:0]   lin_addr;
  logic [12:0]   int_addr;
  logic          last;

  logic [23:0] rom [0:(1<<AW)-1];
  int n_checks = 0;
  int n_pass   = 0;
  int err_cnt  = 0;

  turbo_qpp_addr_gen #(.NUM_BLK(188), .ROM_ADDR_BITS(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .blk_idx(blk_idx), .busy(busy),
    .err(err), .rom_addr(rom_addr), .rom_data(rom_data), .k_out(k_out),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .lin_addr(lin_addr),
    .int_addr(int_addr), .last(last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];
  always @(negedge clk) if (err === 1'b1) err_cnt++;

  function automatic int qpp(input int f1, input int f2, input int k, input int i);
    longint li;
    li = i;
    return int'((longint'(f1) * li + longint'(f2) * li * li) % longint'(k));
  endfunction

  function automatic logic [23:0] kword(input int k);
    return 24'(k);
  endfunction

  function automatic logic [23:0] fword(input int f1, input int f2);
    return 24'((f2 << 9) | f1);
  endfunction

  task automatic run_block(input int b, input int k, input int f1, input int f2,
                           input bit stall, input bit poke, input bit perm,
                           input string tag);
    int exp_i, cyc, e0, exp_int;
    bit hs, poked, perm_ok;
    bit seen[];
    seen  = new[k];
    e0    = err_cnt;
    poked = 1'b0;
    blk_idx = 8'(b);
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL %s busy_after_start got %b want 1", tag, busy);
    else n_pass++;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++;
    if (addr_valid !== 1'b0) $display("FAIL %s valid_early(cycle4) got %b want 0", tag, addr_valid);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (addr_valid !== 1'b1) $display("FAIL %s first_valid(cycle5) got %b want 1", tag, addr_valid);
    else n_pass++;
    n_checks++;
    if (k_out !== 13'(k)) $display("FAIL %s k_out got %0d want %0d", tag, k_out, k);
    else n_pass++;
    exp_i = 0;
    cyc   = 0;
    while (exp_i < k && cyc < 4 * k + 20) begin
      exp_int = qpp(f1, f2, k, exp_i);
      n_checks++;
      if ({addr_valid, lin_addr, int_addr, last} !==
          {1'b1, 13'(exp_i), 13'(exp_int), (exp_i == k - 1)}) begin
        $display("FAIL %s seq got v=%b lin=%0d int=%0d last=%b want v=1 lin=%0d int=%0d last=%b",
                 tag, addr_valid, lin_addr, int_addr, last, exp_i, exp_int, (exp_i == k - 1));
        break;
      end else n_pass++;
      if (poke && exp_i == 5 && !poked) begin
        start   = 1'b1;
        blk_idx = 8'd187;
        poked   = 1'b1;
      end
      addr_ready = stall ? cyc[0] : 1'b1;
      hs = addr_ready;
      if (hs && int_addr < 13'(k)) seen[int_addr] = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (hs) exp_i++;
      cyc++;
    end
    addr_ready = 1'b0;
    n_checks++;
    if (exp_i != k) $display("FAIL %s addr_count got %0d want %0d", tag, exp_i, k);
    else n_pass++;
    n_checks++;
    if ({addr_valid, busy} !== 2'b00) $display("FAIL %s idle_after_last got v=%b busy=%b want 0 0", tag, addr_valid, busy);
    else n_pass++;
    n_checks++;
    if (err_cnt != e0) $display("FAIL %s err_pulses got %0d want 0", tag, err_cnt - e0);
    else n_pass++;
    if (perm) begin
      perm_ok = 1'b1;
      foreach (seen[j]) if (!seen[j]) perm_ok = 1'b0;
      n_checks++;
      if (!perm_ok) $display("FAIL %s permutation got incomplete want all of 0..%0d", tag, k - 1);
      else n_pass++;
    end
    if (poke) begin
      n_checks++;
      if (rom_addr !== AW'(2 * b + 1)) $display("FAIL %s ignored_start rom_addr got %0d want %0d", tag, rom_addr, 2 * b + 1);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({busy, err, addr_valid, last, rom_addr, k_out, lin_addr, int_addr} !== '0)
      $display("FAIL reset_values got busy=%b v=%b rom=%0d k=%0d want all 0", busy, addr_valid, rom_addr, k_out);
    else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, addr_valid} !== 2'b00) $display("FAIL post_reset_idle got busy=%b v=%b want 0 0", busy, addr_valid);
    else n_pass++;
  endtask

  task automatic test_bad_idx();
    int e0;
    e0 = err_cnt;
    blk_idx = 8'd188;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if ({err, busy} !== 2'b10) $display("FAIL bad_idx_pulse got err=%b busy=%b want 1 0", err, busy);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({err, busy, addr_valid} !== 3'b000) $display("FAIL bad_idx_after got err=%b busy=%b v=%b want 0 0 0", err, busy, addr_valid);
    else n_pass++;
    n_checks++;
    if (err_cnt - e0 != 1) $display("FAIL bad_idx_pulse_count got %0d want 1", err_cnt - e0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_gen();
    int cyc;
    bit found;
    blk_idx    = 8'd0;
    start      = 1'b1;
    addr_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (cyc = 0; cyc < 40; cyc++) begin
      if (addr_valid === 1'b1 && lin_addr === 13'd17) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!found) $display("FAIL mid_gen_reach_17 got lin=%0d want 17", lin_addr);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, err, addr_valid, last, rom_addr, k_out, lin_addr, int_addr} !== '0)
      $display("FAIL async_reset got busy=%b v=%b lin=%0d int=%0d k=%0d want all 0", busy, addr_valid, lin_addr, int_addr, k_out);
    else n_pass++;
    addr_ready = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    addr_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, addr_valid} !== 2'b00) $display("FAIL no_emit_after_reset got busy=%b v=%b want 0 0", busy, addr_valid);
    else n_pass++;
    addr_ready = 1'b0;
    run_block(0, 40, 3, 10, 1'b0, 1'b0, 1'b1, "restart_k40");
  endtask

  task automatic test_param_check();
`ifdef TURBO_QPP_PARAM_CHECK_EN
    int e0;
    bit any_valid;
    e0 = err_cnt;
    any_valid = 1'b0;
    blk_idx = 8'd1;
    start   = 1'b1;
    addr_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin
      if (addr_valid === 1'b1) any_valid = 1'b1;
      @(posedge clk); #1;
    end
    addr_ready = 1'b0;
    n_checks++;
    if (any_valid) $display("FAIL param_reject_valid got 1 want 0");
    else n_pass++;
    n_checks++;
    if (err_cnt - e0 != 1) $display("FAIL param_reject_err got %0d want 1", err_cnt - e0);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL param_reject_busy got %b want 0", busy);
    else n_pass++;
`else
    run_block(1, 41, 3, 10, 1'b0, 1'b0, 1'b0, "unchecked_k41");
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (rom[j]) rom[j] = '0;
    rom[0]   = kword(40);
    rom[1]   = fword(3, 10);
    rom[2]   = kword(41);
    rom[3]   = fword(3, 10);
    rom[374] = kword(6144);
    rom[375] = fword(263, 480);

    test_reset();
    run_block(0, 40, 3, 10, 1'b0, 1'b0, 1'b1, "k40");
    run_block(187, 6144, 263, 480, 1'b0, 1'b0, 1'b1, "k6144");
    run_block(0, 40, 3, 10, 1'b1, 1'b1, 1'b1, "k40_stall");
    test_bad_idx();
    test_reset_mid_gen();
    test_param_check();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
